icache_tag_init_ctrl: RTL and testbench

ICACHE_TAG_INIT_CTRL -- requirements
Module: icache_tag_init_ctrl

---
 rtl/icache_tag_init_pkg.sv | 15 +
 rtl/icache_tag_init_ctrl.sv | 93 +++++++++
 tb/tb_icache_tag_init_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_tag_init_pkg.sv
// Shared types and helpers for the icache tag-SRAM init/flush controller.
package icache_tag_init_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } tag_state_e;

  // Number of byte lanes needed to cover a data word of the given width.
  function automatic int unsigned be_width(input int unsigned dw);
    return (dw + 7) / 8;
  endfunction

endpackage

// File: rtl/icache_tag_init_ctrl.sv
// Icache tag-SRAM controller: clears every tag entry after reset (INIT) and on
// request (FLUSH), and forwards cache-controller lookups to the single-port SRAM
// whenever no sweep is running or pending.
module icache_tag_init_ctrl
  import icache_tag_init_pkg::*;
#(
  parameter int unsigned NumWords  = 128,
  parameter int unsigned DataWidth = 8,
  localparam int unsigned AddrW    = $clog2(NumWords),
  localparam int unsigned BeW      = be_width(DataWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  output logic                 flush_ack_o,
  output logic                 busy_o,
  input  logic                 lookup_req_i,
  input  logic                 lookup_we_i,
  input  logic [AddrW-1:0]     lookup_addr_i,
  input  logic [DataWidth-1:0] lookup_wdata_i,
  output logic                 lookup_gnt_o,
  output logic                 lookup_rvalid_o,
  output logic [DataWidth-1:0] lookup_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrW-1:0]     sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeW-1:0]       sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam logic [AddrW-1:0] LastIdx = AddrW'(NumWords - 1);

  tag_state_e       state_q;
  logic [AddrW-1:0] cnt_q;
  logic             rvalid_q;
  logic             flush_ack_q;

  logic sweep;
  logic flush_pend;
  logic gnt;

  // A request already acknowledged this cycle must not restart a sweep.
  assign sweep      = (state_q != ST_IDLE);
  assign flush_pend = flush_req_i & ~flush_ack_q;
  assign gnt        = lookup_req_i & (state_q == ST_IDLE) & ~flush_pend;

  // Sweep/lookup control: counter walks every entry once per sweep; a flush
  // pending at the end of INIT chains straight into FLUSH with no idle gap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      flush_ack_q <= 1'b0;
    end else begin
      flush_ack_q <= 1'b0;
      rvalid_q    <= gnt & ~lookup_we_i;
      unique case (state_q)
        ST_INIT, ST_FLUSH: begin
          cnt_q <= cnt_q + AddrW'(1);
          if (cnt_q == LastIdx) begin
            if (state_q == ST_INIT && flush_req_i) begin
              state_q <= ST_FLUSH;
            end else begin
              state_q     <= ST_IDLE;
              flush_ack_q <= (state_q == ST_FLUSH);
            end
          end
        end
        ST_IDLE: begin
          if (flush_pend) state_q <= ST_FLUSH;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign busy_o          = sweep;
  assign flush_ack_o     = flush_ack_q;
  assign lookup_gnt_o    = gnt;
  assign lookup_rvalid_o = rvalid_q;
  assign lookup_rdata_o  = rvalid_q ? sram_rdata_i : '0;

  // SRAM port muxing: sweeps write zeros to cnt, otherwise pass the lookup.
  // The request is gated by reset so nothing is written while it is held.
  assign sram_req_o   = (sweep & ~rst_i) | gnt;
  assign sram_we_o    = sweep ? 1'b1 : lookup_we_i;
  assign sram_addr_o  = sweep ? cnt_q : lookup_addr_i;
  assign sram_wdata_o = sweep ? '0 : lookup_wdata_i;
  assign sram_be_o    = '1;

endmodule

// File: tb/tb_icache_tag_init_ctrl.sv
// Directed bench for icache_tag_init_ctrl with a 16-entry tag SRAM model.
module tb_icache_tag_init_ctrl;

  localparam int NW = 16;
  localparam int DW = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_req_i;
  logic       flush_ack_o;
  logic       busy_o;
  logic       lookup_req_i;
  logic       lookup_we_i;
  logic [3:0] lookup_addr_i;
  logic [7:0] lookup_wdata_i;
  logic       lookup_gnt_o;
  logic       lookup_rvalid_o;
  logic [7:0] lookup_rdata_o;
  logic       sram_req_o;
  logic       sram_we_o;
  logic [3:0] sram_addr_o;
  logic [7:0] sram_wdata_o;
  logic [0:0] sram_be_o;
  logic [7:0] sram_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  icache_tag_init_ctrl #(.NumWords(NW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
    .lookup_req_i(lookup_req_i), .lookup_we_i(lookup_we_i),
    .lookup_addr_i(lookup_addr_i), .lookup_wdata_i(lookup_wdata_i),
    .lookup_gnt_o(lookup_gnt_o), .lookup_rvalid_o(lookup_rvalid_o),
    .lookup_rdata_o(lookup_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  // Single-port SRAM model with one-cycle read latency.
  logic [7:0] mem [NW];
  initial sram_rdata_i = 8'h00;
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i     <= mem[sram_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic next_cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk_sweep_cycle(input string pfx, input int i);
    chk($sformatf("%s_req%0d", pfx, i), sram_req_o, 1);
    chk($sformatf("%s_we%0d", pfx, i), sram_we_o, 1);
    chk($sformatf("%s_addr%0d", pfx, i), sram_addr_o, i % NW);
    chk($sformatf("%s_wd%0d", pfx, i), sram_wdata_o, 0);
    chk($sformatf("%s_busy%0d", pfx, i), busy_o, 1);
    chk($sformatf("%s_ack%0d", pfx, i), flush_ack_o, 0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, busy_o, 1);
    chk({pfx, "_gnt"}, lookup_gnt_o, 0);
    chk({pfx, "_rvalid"}, lookup_rvalid_o, 0);
    chk({pfx, "_rdata"}, lookup_rdata_o, 0);
    chk({pfx, "_ack"}, flush_ack_o, 0);
    chk({pfx, "_sreq"}, sram_req_o, 0);
  endtask

  initial begin
    int rv_cnt;
    int ack_cnt;
    for (int k = 0; k < NW; k++) mem[k] = 8'hFF;
    rst_i = 1'b1; flush_req_i = 1'b0;
    lookup_req_i = 1'b1; lookup_we_i = 1'b0; lookup_addr_i = 4'd0; lookup_wdata_i = 8'h00;

    // Reset state, with a lookup request pending.
    next_cyc(); next_cyc();
    chk_reset_outputs("rst");
    lookup_req_i = 1'b0;

    // INIT sweep after release.
    @(negedge clk_i); rst_i = 1'b0; #1;
    for (int i = 0; i < NW; i++) begin
      chk_sweep_cycle("init", i);
      next_cyc();
    end
    chk("init_done_busy", busy_o, 0);
    chk("init_done_ack", flush_ack_o, 0);
    chk("init_done_sreq", sram_req_o, 0);
    chk("init_mem7", mem[7], 8'h00);

    // Write 0x83 to addr 5, then read it back.
    @(negedge clk_i);
    lookup_req_i = 1'b1; lookup_we_i = 1'b1; lookup_addr_i = 4'd5; lookup_wdata_i = 8'h83; #1;
    chk("wr5_gnt", lookup_gnt_o, 1);
    chk("wr5_sreq", sram_req_o, 1);
    chk("wr5_swe", sram_we_o, 1);
    chk("wr5_saddr", sram_addr_o, 5);
    chk("wr5_swd", sram_wdata_o, 8'h83);
    @(negedge clk_i);
    lookup_we_i = 1'b0; #1;
    chk("wr5_no_rvalid", lookup_rvalid_o, 0);
    chk("rd5_gnt", lookup_gnt_o, 1);
    chk("rd5_swe", sram_we_o, 0);
    @(negedge clk_i);
    lookup_req_i = 1'b0; #1;
    chk("rd5_rvalid", lookup_rvalid_o, 1);
    chk("rd5_rdata", lookup_rdata_o, 8'h83);
    next_cyc();
    chk("rd5_rvalid_end", lookup_rvalid_o, 0);
    chk("rd5_rdata_zero", lookup_rdata_o, 0);

    // Write 0x5A to addr 3, read it, count rvalid pulses.
    @(negedge clk_i);
    lookup_req_i = 1'b1; lookup_we_i = 1'b1; lookup_addr_i = 4'd3; lookup_wdata_i = 8'h5A;
    @(negedge clk_i);
    lookup_we_i = 1'b0;
    @(negedge clk_i);
    lookup_req_i = 1'b0; #1;
    rv_cnt = 0;
    chk("rd3_rdata", lookup_rdata_o, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      if (lookup_rvalid_o) rv_cnt++;
      next_cyc();
    end
    chk("rd3_rvalid_count", rv_cnt, 1);
    chk("rd3_rdata_idle_zero", lookup_rdata_o, 0);

    // Flush and lookup together: flush wins.
    @(negedge clk_i);
    flush_req_i = 1'b1; lookup_req_i = 1'b1; lookup_we_i = 1'b0; lookup_addr_i = 4'd7; #1;
    chk("fl_gnt_blocked", lookup_gnt_o, 0);
    chk("fl_sreq_blocked", sram_req_o, 0);
    chk("fl_busy_pre", busy_o, 0);
    next_cyc();
    for (int i = 0; i < NW; i++) begin
      chk_sweep_cycle("fl", i);
      chk($sformatf("fl_gnt%0d", i), lookup_gnt_o, 0);
      next_cyc();
    end
    chk("fl_ack", flush_ack_o, 1);
    chk("fl_ack_busy", busy_o, 0);
    chk("fl_ack_gnt", lookup_gnt_o, 1);
    @(negedge clk_i);
    flush_req_i = 1'b0; #1;
    chk("fl_ack_once", flush_ack_o, 0);
    chk("fl_post_busy", busy_o, 0);
    chk("fl_post_gnt", lookup_gnt_o, 1);
    chk("fl_mem5_cleared", mem[5], 8'h00);
    @(negedge clk_i);
    lookup_req_i = 1'b0; #1;

    // Reset in the middle of a FLUSH sweep at cnt 9.
    @(negedge clk_i);
    flush_req_i = 1'b1;
    next_cyc();
    for (int i = 0; i < 9; i++) next_cyc();
    chk("mid_addr9", sram_addr_o, 9);
    rst_i = 1'b1; flush_req_i = 1'b0; #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk_i); rst_i = 1'b0; #1;
    ack_cnt = 0;
    for (int i = 0; i < NW; i++) begin
      chk_sweep_cycle("reinit", i);
      next_cyc();
    end
    chk("reinit_done_busy", busy_o, 0);
    chk("reinit_done_ack", flush_ack_o, 0);

    // Flush held from reset release: INIT then FLUSH back to back, one ack.
    @(negedge clk_i);
    rst_i = 1'b1; flush_req_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    for (int i = 0; i < 2 * NW; i++) begin
      chk_sweep_cycle("chain", i);
      next_cyc();
    end
    for (int i = 0; i < 3; i++) begin
      if (flush_ack_o) ack_cnt++;
      chk($sformatf("chain_idle_busy%0d", i), busy_o, 0);
      @(negedge clk_i);
      flush_req_i = 1'b0; #1;
    end
    chk("chain_ack_count", ack_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
